core_run_scheduler: RTL and testbench

- Sequences the two pipelined cores: boots core 0 after reset and services their awaken, pause, resume and halt events.
- Drives each core's pc_passed and stall_num inputs.
- Consumes each core's pc_out, pauseResume and halt_ outputs.
- Sits at top level between the cores; memory stays shared outside this block.

---
 rtl/core_run_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_core_run_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/core_run_scheduler.sv
// -----------------------------------------------------------------------------
// core_run_scheduler
//
// Sequences the two pipelined cores. Core 0 is booted out of reset; after that
// the block services awaken, pause, resume and halt events raised by either
// core and drives each core's pc_passed / stall_num inputs. Every output is
// registered.
//
// Ports:
//   clk              system clock
//   rst              asynchronous, active-high reset
//   c0_pc_out        core 0 awaken   : [17] valid, [16] target, [15:0] PC
//   c1_pc_out        core 1 awaken   : same format
//   c0_pause_resume  core 0 request  : [2] valid, [1] 1=resume/0=pause, [0] target
//   c1_pause_resume  core 1 request  : same format
//   c0_halt          core 0 halt_
//   c1_halt          core 1 halt_
//   c0_pc_passed     to core 0       : [16] load strobe, [15:0] PC
//   c1_pc_passed     to core 1       : same format
//   c0_stall_num     to core 0
//   c1_stall_num     to core 1
//   c0_state         core 0 state (IDLE=0, RUN=1, PAUSED=2, HALTED=3)
//   c1_state         core 1 state
//   all_done         no core RUN or PAUSED
//   deadlock         at least one core PAUSED and none RUN
//   err              sticky illegal-request flag
// -----------------------------------------------------------------------------
module core_run_scheduler #(
   parameter logic [15:0] BOOT_PC     = 16'h0000,
   parameter logic [2:0]  PAUSE_STALL = 3'd5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [17:0] c0_pc_out,
   input  logic [17:0] c1_pc_out,
   input  logic [2:0]  c0_pause_resume,
   input  logic [2:0]  c1_pause_resume,
   input  logic        c0_halt,
   input  logic        c1_halt,
   output logic [16:0] c0_pc_passed,
   output logic [16:0] c1_pc_passed,
   output logic [2:0]  c0_stall_num,
   output logic [2:0]  c1_stall_num,
   output logic [1:0]  c0_state,
   output logic [1:0]  c1_state,
   output logic        all_done,
   output logic        deadlock,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      HALTED = 2'd3
   } core_st_t;

   // Per-core views of the inputs so both sources share one evaluation loop.
   logic [17:0] pc_out_a [2];
   logic [2:0]  pr_a     [2];
   logic        halt_a   [2];

   assign pc_out_a[0] = c0_pc_out;
   assign pc_out_a[1] = c1_pc_out;
   assign pr_a[0]     = c0_pause_resume;
   assign pr_a[1]     = c1_pause_resume;
   assign halt_a[0]   = c0_halt;
   assign halt_a[1]   = c1_halt;

   core_st_t    st_q    [2];
   core_st_t    st_d    [2];
   logic [1:0]  tok_q;
   logic [1:0]  tok_d;
   logic        err_q;
   logic        err_d;
   logic [16:0] pcp_q   [2];
   logic [16:0] pcp_d   [2];
   logic [2:0]  stall_q [2];
   logic [2:0]  stall_d [2];
   logic        all_done_q;
   logic        all_done_d;
   logic        deadlock_q;
   logic        deadlock_d;
   logic [1:0]  halting;

   // A core is halting when its halt_ is high while it is RUN or PAUSED.
   // Halting cores neither issue requests nor accept requests aimed at them.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         halting[i] = halt_a[i] && (st_q[i] == RUN || st_q[i] == PAUSED);
      end
   end

   // Next-state evaluation. Requests are applied in a fixed order (core 0
   // then core 1, awaken before pause/resume) against the running next-state
   // so that same-edge events on one target compose. Source eligibility is
   // judged on the current state: a PAUSED core's frozen writeback stage
   // keeps re-presenting its request and must be ignored.
   always_comb begin
      logic tgt;
      tgt        = 1'b0;
      st_d       = st_q;
      tok_d      = tok_q;
      err_d      = err_q;
      pcp_d[0]   = 17'd0;
      pcp_d[1]   = 17'd0;
      stall_d[0] = 3'd0;
      stall_d[1] = 3'd0;
      all_done_d = 1'b1;
      deadlock_d = 1'b0;

      for (int s = 0; s < 2; s++) begin
         if (st_q[s] == RUN && !halting[s]) begin
            // Awaken: only an IDLE, non-self target may be started.
            if (pc_out_a[s][17]) begin
               tgt = pc_out_a[s][16];
               if (!halting[tgt]) begin
                  if (tgt == s[0] || st_d[tgt] != IDLE) begin
                     err_d = 1'b1;
                  end else begin
                     st_d[tgt]  = RUN;
                     pcp_d[tgt] = {1'b1, pc_out_a[s][15:0]};
                  end
               end
            end
            // Pause / resume. A resume arriving while the target still runs
            // is remembered in the token and cancels the next pause.
            if (pr_a[s][2]) begin
               tgt = pr_a[s][0];
               if (!halting[tgt]) begin
                  if (pr_a[s][1]) begin
                     case (st_d[tgt])
                        PAUSED:  st_d[tgt] = RUN;
                        RUN: begin
                           if (tok_d[tgt]) err_d = 1'b1;
                           else            tok_d[tgt] = 1'b1;
                        end
                        default: err_d = 1'b1;
                     endcase
                  end else begin
                     if (st_d[tgt] == RUN) begin
                        if (tok_d[tgt]) tok_d[tgt] = 1'b0;
                        else            st_d[tgt]  = PAUSED;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
               end
            end
         end
      end

      for (int i = 0; i < 2; i++) begin
         if (halting[i]) begin
            st_d[i]  = HALTED;
            pcp_d[i] = 17'd0;
         end
         stall_d[i] = (st_d[i] == PAUSED) ? PAUSE_STALL : 3'd0;
         if (st_d[i] == RUN || st_d[i] == PAUSED) all_done_d = 1'b0;
      end
      deadlock_d = (st_d[0] == PAUSED || st_d[1] == PAUSED) &&
                   (st_d[0] != RUN && st_d[1] != RUN);
   end

   // State / output register stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q[0]    <= RUN;
         st_q[1]    <= IDLE;
         tok_q      <= 2'b00;
         err_q      <= 1'b0;
         pcp_q[0]   <= {1'b1, BOOT_PC};
         pcp_q[1]   <= 17'd0;
         stall_q[0] <= 3'd0;
         stall_q[1] <= 3'd0;
         all_done_q <= 1'b0;
         deadlock_q <= 1'b0;
      end else begin
         st_q       <= st_d;
         tok_q      <= tok_d;
         err_q      <= err_d;
         pcp_q      <= pcp_d;
         stall_q    <= stall_d;
         all_done_q <= all_done_d;
         deadlock_q <= deadlock_d;
      end
   end

   assign c0_pc_passed = pcp_q[0];
   assign c1_pc_passed = pcp_q[1];
   assign c0_stall_num = stall_q[0];
   assign c1_stall_num = stall_q[1];
   assign c0_state     = st_q[0];
   assign c1_state     = st_q[1];
   assign all_done     = all_done_q;
   assign deadlock     = deadlock_q;
   assign err          = err_q;

endmodule

// File: tb/tb_core_run_scheduler.sv
module tb_core_run_scheduler;

   logic        clk;
   logic        rst;
   logic [17:0] c0_pc_out;
   logic [17:0] c1_pc_out;
   logic [2:0]  c0_pause_resume;
   logic [2:0]  c1_pause_resume;
   logic        c0_halt;
   logic        c1_halt;
   logic [16:0] c0_pc_passed;
   logic [16:0] c1_pc_passed;
   logic [2:0]  c0_stall_num;
   logic [2:0]  c1_stall_num;
   logic [1:0]  c0_state;
   logic [1:0]  c1_state;
   logic        all_done;
   logic        deadlock;
   logic        err;

   int checks;
   int failures;

   core_run_scheduler #(
      .BOOT_PC     (16'h0040),
      .PAUSE_STALL (3'd5)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .c0_pc_out       (c0_pc_out),
      .c1_pc_out       (c1_pc_out),
      .c0_pause_resume (c0_pause_resume),
      .c1_pause_resume (c1_pause_resume),
      .c0_halt         (c0_halt),
      .c1_halt         (c1_halt),
      .c0_pc_passed    (c0_pc_passed),
      .c1_pc_passed    (c1_pc_passed),
      .c0_stall_num    (c0_stall_num),
      .c1_stall_num    (c1_stall_num),
      .c0_state        (c0_state),
      .c1_state        (c1_state),
      .all_done        (all_done),
      .deadlock        (deadlock),
      .err             (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle 1 ns past the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      c0_pc_out = '0; c1_pc_out = '0;
      c0_pause_resume = '0; c1_pause_resume = '0;
      c0_halt = 1'b0; c1_halt = 1'b0;
      #3;
      checks++; if (c0_state !== 2'd1) begin failures++; $display("FAIL rst_c0_state got=%0d exp=1", c0_state); end
      checks++; if (c1_state !== 2'd0) begin failures++; $display("FAIL rst_c1_state got=%0d exp=0", c1_state); end
      checks++; if (c0_pc_passed !== 17'h10040) begin failures++; $display("FAIL rst_c0_pc got=%h exp=10040", c0_pc_passed); end
      checks++; if (c1_pc_passed !== 17'h0) begin failures++; $display("FAIL rst_c1_pc got=%h exp=0", c1_pc_passed); end
      checks++; if ({c0_stall_num, c1_stall_num} !== 6'd0) begin failures++; $display("FAIL rst_stall got=%h exp=0", {c0_stall_num, c1_stall_num}); end
      checks++; if ({err, all_done, deadlock} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {err, all_done, deadlock}); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (c0_pc_passed !== 17'h10040) begin failures++; $display("FAIL boot_strobe_held got=%h exp=10040", c0_pc_passed); end
      tick();
      checks++; if (c0_pc_passed !== 17'h0) begin failures++; $display("FAIL boot_strobe_clear got=%h exp=0", c0_pc_passed); end
      checks++; if ({c0_state, c1_state} !== 4'b0100) begin failures++; $display("FAIL boot_states got=%b exp=0100", {c0_state, c1_state}); end
   endtask

   task automatic test_awaken();
      c0_pc_out = 18'h3_0100;
      tick();
      c0_pc_out = '0;
      checks++; if (c1_pc_passed !== 17'h10100) begin failures++; $display("FAIL awaken_strobe got=%h exp=10100", c1_pc_passed); end
      checks++; if (c1_state !== 2'd1) begin failures++; $display("FAIL awaken_state got=%0d exp=1", c1_state); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL awaken_err got=%b exp=0", err); end
      tick();
      checks++; if (c1_pc_passed !== 17'h0) begin failures++; $display("FAIL awaken_strobe_clear got=%h exp=0", c1_pc_passed); end
   endtask

   task automatic test_pause_resume();
      c0_pause_resume = 3'b101;
      tick();
      c0_pause_resume = '0;
      checks++; if (c1_state !== 2'd2) begin failures++; $display("FAIL pause_state got=%0d exp=2", c1_state); end
      checks++; if (c1_stall_num !== 3'd5) begin failures++; $display("FAIL pause_stall got=%0d exp=5", c1_stall_num); end
      checks++; if (deadlock !== 1'b0) begin failures++; $display("FAIL pause_deadlock got=%b exp=0", deadlock); end
      // Paused c1 keeps presenting "pause core 0": must be ignored.
      c1_pause_resume = 3'b100;
      tick();
      tick();
      c1_pause_resume = '0;
      checks++; if (c0_state !== 2'd1) begin failures++; $display("FAIL paused_src_ignored got=%0d exp=1", c0_state); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL paused_src_err got=%b exp=0", err); end
      checks++; if (c1_stall_num !== 3'd5) begin failures++; $display("FAIL pause_stall_hold got=%0d exp=5", c1_stall_num); end
      c0_pause_resume = 3'b111;
      tick();
      c0_pause_resume = '0;
      checks++; if (c1_state !== 2'd1) begin failures++; $display("FAIL resume_state got=%0d exp=1", c1_state); end
      checks++; if (c1_stall_num !== 3'd0) begin failures++; $display("FAIL resume_stall got=%0d exp=0", c1_stall_num); end
   endtask

   task automatic test_same_edge();
      // c0 pauses c1 and c1 resumes itself on the same edge.
      c0_pause_resume = 3'b101;
      c1_pause_resume = 3'b111;
      tick();
      c0_pause_resume = '0;
      c1_pause_resume = '0;
      checks++; if (c1_state !== 2'd1) begin failures++; $display("FAIL same_edge_state got=%0d exp=1", c1_state); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL same_edge_err got=%b exp=0", err); end
   endtask

   task automatic test_token();
      c0_pause_resume = 3'b111;
      tick();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL token_set_err got=%b exp=0", err); end
      c0_pause_resume = 3'b101;
      tick();
      checks++; if (c1_state !== 2'd1) begin failures++; $display("FAIL token_cancel_state got=%0d exp=1", c1_state); end
      checks++; if (c1_stall_num !== 3'd0) begin failures++; $display("FAIL token_cancel_stall got=%0d exp=0", c1_stall_num); end
      c0_pause_resume = 3'b111;
      tick();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL token_second_err got=%b exp=0", err); end
      tick();
      c0_pause_resume = '0;
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL token_third_err got=%b exp=1", err); end
      tick();
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
   endtask

   task automatic test_halt_deadlock();
      // Token for c1 is still set: first self-pause consumes it, second pauses.
      c1_pause_resume = 3'b101;
      tick();
      checks++; if (c1_state !== 2'd1) begin failures++; $display("FAIL selfpause_token got=%0d exp=1", c1_state); end
      tick();
      checks++; if (c1_state !== 2'd2) begin failures++; $display("FAIL selfpause_state got=%0d exp=2", c1_state); end
      c0_halt = 1'b1;
      tick();
      c0_halt = 1'b0;
      checks++; if (c0_state !== 2'd3) begin failures++; $display("FAIL halt_state got=%0d exp=3", c0_state); end
      checks++; if (deadlock !== 1'b1) begin failures++; $display("FAIL halt_deadlock got=%b exp=1", deadlock); end
      checks++; if (all_done !== 1'b0) begin failures++; $display("FAIL halt_all_done got=%b exp=0", all_done); end
      c1_pause_resume = 3'b110;
      c1_pc_out = 18'h2_0200;
      tick();
      tick();
      c1_pause_resume = '0;
      c1_pc_out = '0;
      checks++; if ({c0_state, c1_state} !== 4'b1110) begin failures++; $display("FAIL halted_terminal got=%b exp=1110", {c0_state, c1_state}); end
      checks++; if (c0_pc_passed !== 17'h0) begin failures++; $display("FAIL halted_pc got=%h exp=0", c0_pc_passed); end
      checks++; if (c0_stall_num !== 3'd0) begin failures++; $display("FAIL halted_stall got=%0d exp=0", c0_stall_num); end
   endtask

   task automatic test_async_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      // Self-awaken is illegal and raises err.
      c0_pc_out = 18'h2_0500;
      tick();
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL self_awaken_err got=%b exp=1", err); end
      checks++; if (c0_pc_passed !== 17'h0) begin failures++; $display("FAIL self_awaken_pc got=%h exp=0", c0_pc_passed); end
      c0_pc_out = 18'h3_1234;
      tick();
      c0_pc_out = '0;
      checks++; if (c1_pc_passed !== 17'h11234) begin failures++; $display("FAIL rst2_strobe got=%h exp=11234", c1_pc_passed); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (c1_pc_passed !== 17'h0) begin failures++; $display("FAIL async_c1_pc got=%h exp=0", c1_pc_passed); end
      checks++; if (c0_pc_passed !== 17'h10040) begin failures++; $display("FAIL async_c0_pc got=%h exp=10040", c0_pc_passed); end
      checks++; if ({c0_state, c1_state} !== 4'b0100) begin failures++; $display("FAIL async_states got=%b exp=0100", {c0_state, c1_state}); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL async_err got=%b exp=0", err); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_awaken();
      test_pause_resume();
      test_same_edge();
      test_token();
      test_halt_deadlock();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
